// File: rtl/fetch_decode_buffer_pkg.sv
// Shared types for the fetch/decode instruction buffer.
//   - default widths for depth, instruction ID and exception code
//   - exception_code_t / id_t, the stored entry layout and the buffer state
//   - entry_width(): flat bit width of one stored entry for given field widths
package fetch_decode_buffer_pkg;

    localparam int unsigned FDB_DEPTH   = 4;
    localparam int unsigned FDB_ID_W    = 3;
    localparam int unsigned FDB_ECODE_W = 5;

    typedef logic [FDB_ECODE_W-1:0] exception_code_t;
    typedef logic [FDB_ID_W-1:0]    id_t;

    typedef struct packed {
        logic [31:0]     pc;
        logic [31:0]     instruction;
        logic            ok;
        exception_code_t error_code;
        id_t             id;
    } fetch_buffer_entry_t;

    typedef enum logic {
        OPEN    = 1'b0,
        BLOCKED = 1'b1
    } fetch_buffer_state_t;

    // pc + instruction + ok + error_code + id
    function automatic int unsigned entry_width(input int unsigned id_w, input int unsigned ecode_w);
        return 32 + 32 + 1 + ecode_w + id_w;
    endfunction

endpackage

// File: rtl/fetch_decode_buffer_if.sv
// Fetch-side and decode-side signal bundle of the instruction buffer.
//   master : fetch/decode environment (drives fetch_*, flush, decode_advance)
//   slave  : the buffer (drives fetch_ready, decode_*, occupancy)
interface fetch_decode_buffer_if
    import fetch_decode_buffer_pkg::*;
#(
    parameter int unsigned DEPTH   = FDB_DEPTH,
    parameter int unsigned ID_W    = FDB_ID_W,
    parameter int unsigned ECODE_W = FDB_ECODE_W
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               fetch_valid;
    logic               fetch_ready;
    logic [31:0]        fetch_pc;
    logic [31:0]        fetch_instruction;
    logic               fetch_ok;
    logic [ECODE_W-1:0] fetch_error_code;
    logic [ID_W-1:0]    fetch_id;
    logic               flush;
    logic               decode_valid;
    logic [31:0]        decode_pc;
    logic [31:0]        decode_instruction;
    logic               decode_ok;
    logic [ECODE_W-1:0] decode_error_code;
    logic [ID_W-1:0]    decode_id;
    logic               decode_advance;
    logic [CNT_W-1:0]   occupancy;

    modport master (
        output fetch_valid, fetch_pc, fetch_instruction, fetch_ok, fetch_error_code, fetch_id,
        output flush, decode_advance,
        input  fetch_ready, decode_valid, decode_pc, decode_instruction, decode_ok,
        input  decode_error_code, decode_id, occupancy
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_instruction, fetch_ok, fetch_error_code, fetch_id,
        input  flush, decode_advance,
        output fetch_ready, decode_valid, decode_pc, decode_instruction, decode_ok,
        output decode_error_code, decode_id, occupancy
    );

endinterface

// File: rtl/fetch_buffer_ram.sv
// DEPTH x WIDTH storage for the instruction buffer: one synchronous write
// port and one asynchronous read port (maps to LUTRAM). No reset; validity
// of each slot is tracked by the controller.
//   clk   : clock
//   we    : write enable
//   waddr : write slot, wdata : write data
//   raddr : read slot,  rdata : read data (combinational)
module fetch_buffer_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 73
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_buffer.sv
// Elastic first-word-fall-through instruction buffer between fetch and decode.
// Accepts ID-tagged fetched instructions, presents the oldest at decode_*,
// pops on decode_advance, clears on flush. Once a faulted fetch (ok=0) is
// accepted, further pushes are refused until flush.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_decode_buffer_if.slave (fetch handshake, decode head,
//              flush, decode_advance, occupancy)
// DEPTH/ID_W/ECODE_W must match the connected interface instance.
module fetch_decode_buffer
    import fetch_decode_buffer_pkg::*;
#(
    parameter int unsigned DEPTH   = FDB_DEPTH,
    parameter int unsigned ID_W    = FDB_ID_W,
    parameter int unsigned ECODE_W = FDB_ECODE_W
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_decode_buffer_if.slave bus
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = entry_width(ID_W, ECODE_W);

    fetch_buffer_state_t state, state_next;
    logic [PTR_W-1:0]    rptr, wptr;
    logic [CNT_W-1:0]    count;
    logic                ready;
    logic                valid;
    logic                push;
    logic                pop;
    logic [ENTRY_W-1:0]  wdata;
    logic [ENTRY_W-1:0]  rdata;

    // Ready never looks at decode_advance: a full buffer cannot push while popping.
    assign ready = (state == OPEN) && (count != CNT_W'(DEPTH)) && !bus.flush;
    assign valid = (count != '0);
    assign push  = bus.fetch_valid && ready;
    assign pop   = bus.decode_advance && valid;

    assign bus.fetch_ready  = ready;
    assign bus.decode_valid = valid;
    assign bus.occupancy    = count;

    assign wdata = {bus.fetch_pc, bus.fetch_instruction, bus.fetch_ok,
                    bus.fetch_error_code, bus.fetch_id};
    assign {bus.decode_pc, bus.decode_instruction, bus.decode_ok,
            bus.decode_error_code, bus.decode_id} = rdata;

    fetch_buffer_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wptr),
        .wdata (wdata),
        .raddr (rptr),
        .rdata (rdata)
    );

    always_comb begin
        state_next = state;
        if (bus.flush) begin
            state_next = OPEN;
        end else if (push && !bus.fetch_ok) begin
            state_next = BLOCKED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OPEN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
module tb_fetch_decode_buffer;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst;

    fetch_decode_buffer_if #(.DEPTH(DEPTH), .ID_W(3), .ECODE_W(5)) bus ();

    fetch_decode_buffer #(.DEPTH(DEPTH), .ID_W(3), .ECODE_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: an ordered queue of accepted entries plus a blocked flag.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ok;
        logic [4:0]  ec;
        logic [2:0]  id;
    } m_ent_t;

    m_ent_t mq[$];
    bit     m_blocked = 0;

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic        ok;
        logic [4:0]  ec;
        logic [2:0]  id;
        logic        fl;
        logic        adv;
        logic        e_ready;
        logic        e_valid;
        int          e_occ;
        logic [31:0] e_pc;
        logic        e_ok;
        logic [4:0]  e_ec;
        logic [2:0]  e_id;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic fv, input logic [31:0] pc, input logic ok,
                                input logic [4:0] ec, input logic [2:0] id, input logic fl,
                                input logic adv, input logic e_ready, input logic e_valid,
                                input int e_occ, input logic [31:0] e_pc, input logic e_ok,
                                input logic [4:0] e_ec, input logic [2:0] e_id);
        vec_t v;
        v.fv = fv; v.pc = pc; v.ok = ok; v.ec = ec; v.id = id; v.fl = fl; v.adv = adv;
        v.e_ready = e_ready; v.e_valid = e_valid; v.e_occ = e_occ;
        v.e_pc = e_pc; v.e_ok = e_ok; v.e_ec = e_ec; v.e_id = e_id;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] instr,
                         input logic ok, input logic [4:0] ec, input logic [2:0] id,
                         input logic fl, input logic adv);
        bus.fetch_valid       = fv;
        bus.fetch_pc          = pc;
        bus.fetch_instruction = instr;
        bus.fetch_ok          = ok;
        bus.fetch_error_code  = ec;
        bus.fetch_id          = id;
        bus.flush             = fl;
        bus.decode_advance    = adv;
    endtask

    // Clock edge plus model update from the bench-driven inputs.
    task automatic advance();
        bit     m_ready;
        m_ent_t e;
        m_ready = !m_blocked && (mq.size() < DEPTH) && !bus.flush;
        @(posedge clk);
        if (bus.flush) begin
            mq.delete();
            m_blocked = 0;
        end else begin
            if (bus.decode_advance && mq.size() > 0) void'(mq.pop_front());
            if (bus.fetch_valid && m_ready) begin
                e.pc = bus.fetch_pc; e.instr = bus.fetch_instruction; e.ok = bus.fetch_ok;
                e.ec = bus.fetch_error_code; e.id = bus.fetch_id;
                mq.push_back(e);
                if (!bus.fetch_ok) m_blocked = 1;
            end
        end
        #1;
    endtask

    task automatic check_model();
        chk("rand_ready", 32'(bus.fetch_ready),
            32'(!m_blocked && (mq.size() < DEPTH) && !bus.flush));
        chk("rand_valid", 32'(bus.decode_valid), 32'(mq.size() != 0));
        chk("rand_occ", 32'(bus.occupancy), 32'(mq.size()));
        if (mq.size() != 0) begin
            chk("rand_pc", bus.decode_pc, mq[0].pc);
            chk("rand_instr", bus.decode_instruction, mq[0].instr);
            chk("rand_ok", 32'(bus.decode_ok), 32'(mq[0].ok));
            chk("rand_ec", 32'(bus.decode_error_code), 32'(mq[0].ec));
            chk("rand_id", 32'(bus.decode_id), 32'(mq[0].id));
        end
    endtask

    initial begin
        logic [2:0] nid;

        // Directed sequence; expectations are the outputs seen before each edge.
        for (int i = 0; i < 4; i++)
            add(1, 32'h100 + 32'(4 * i), 1, 0, 3'(i), 0, 0, 1, i != 0, i, 32'h100, 1, 0, 0);
        add(1, 32'h110, 1, 0, 4, 0, 1, 0, 1, 4, 32'h100, 1, 0, 0);   // full: pop, no push
        add(0, 0, 1, 0, 0, 0, 0, 1, 1, 3, 32'h104, 1, 0, 1);
        add(0, 0, 1, 0, 0, 0, 1, 1, 1, 3, 32'h104, 1, 0, 1);
        add(0, 0, 1, 0, 0, 0, 1, 1, 1, 2, 32'h108, 1, 0, 2);
        for (int k = 0; k < 10; k++)                                  // push+pop across wrap
            add(1, 32'h400 + 32'(4 * k), 1, 0, 3'((4 + k) % 8), 0, 1, 1, 1, 1,
                (k == 0) ? 32'h10C : 32'h400 + 32'(4 * (k - 1)), 1, 0, 3'((3 + k) % 8));
        add(0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 32'h424, 1, 0, 5);
        add(1, 32'h200, 0, 1, 6, 0, 0, 1, 0, 0, 0, 0, 0, 0);          // faulted push
        add(1, 32'h204, 1, 0, 7, 0, 0, 0, 1, 1, 32'h200, 0, 1, 6);
        add(1, 32'h204, 1, 0, 7, 0, 1, 0, 1, 1, 32'h200, 0, 1, 6);
        add(1, 32'h204, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);          // still blocked
        add(1, 32'h204, 1, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0);          // flush
        add(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            add(1, 32'h500 + 32'(4 * i), 1, 0, 3'(i), 0, 0, 1, i != 0, i, 32'h500, 1, 0, 0);
        add(1, 32'h50C, 1, 0, 3, 1, 1, 0, 1, 3, 32'h500, 1, 0, 0);    // flush with fetch_valid
        add(1, 32'h300, 1, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 32'h300, 1, 0, 3);
        add(0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 32'h300, 1, 0, 3);
        add(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);                // advance while empty
        add(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        rst = 1'b1;
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_blocked = 0;
        #3;
        chk("reset_ready", 32'(bus.fetch_ready), 1);
        chk("reset_valid", 32'(bus.decode_valid), 0);
        chk("reset_occ", 32'(bus.occupancy), 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].fv, tbl[i].pc, ~tbl[i].pc, tbl[i].ok, tbl[i].ec, tbl[i].id,
                  tbl[i].fl, tbl[i].adv);
            #3;
            chk($sformatf("v%0d_ready", i), 32'(bus.fetch_ready), 32'(tbl[i].e_ready));
            chk($sformatf("v%0d_valid", i), 32'(bus.decode_valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d_occ", i), 32'(bus.occupancy), 32'(tbl[i].e_occ));
            if (tbl[i].e_valid) begin
                chk($sformatf("v%0d_pc", i), bus.decode_pc, tbl[i].e_pc);
                chk($sformatf("v%0d_instr", i), bus.decode_instruction, ~tbl[i].e_pc);
                chk($sformatf("v%0d_ok", i), 32'(bus.decode_ok), 32'(tbl[i].e_ok));
                chk($sformatf("v%0d_ec", i), 32'(bus.decode_error_code), 32'(tbl[i].e_ec));
                chk($sformatf("v%0d_id", i), 32'(bus.decode_id), 32'(tbl[i].e_id));
            end
            advance();
        end

        // Randomized traffic against the queue model.
        nid = 3'd4;
        for (int c = 0; c < 3000; c++) begin
            logic fv, ok, fl, adv, will_push;
            fv  = ($urandom_range(0, 9) < 7);
            ok  = ($urandom_range(0, 15) != 0);
            fl  = ($urandom_range(0, 31) == 0);
            adv = ($urandom_range(0, 9) < 5);
            drive(fv, $urandom, $urandom, ok, 5'($urandom), nid, fl, adv);
            will_push = fv && !m_blocked && (mq.size() < DEPTH) && !fl;
            #3;
            check_model();
            advance();
            if (will_push) nid = nid + 3'd1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
